// File: rtl/board_ctrl.sv
// Tic-tac-toe board controller: validates moves, keeps per-player occupancy
// bitmaps and raises sticky win/draw flags after a one-cycle line check.
module board_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       player,
    output logic       move_ack,
    output logic       move_err,
    output logic [8:0] p1_board,
    output logic [8:0] p2_board,
    output logic       p1_win,
    output logic       p2_win,
    output logic       draw,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] p1_q, p1_d;
    logic [8:0] p2_q, p2_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       p1w_q, p1w_d;
    logic       p2w_q, p2w_d;
    logic       draw_q, draw_d;

    logic [8:0] occupied;
    logic [8:0] sel;
    logic       legal;
    logic       w1, w2, full;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // A one-hot cell select; positions 9..15 shift out to zero and are rejected.
    assign occupied = p1_q | p2_q;
    assign sel      = 9'd1 << move_pos;
    assign legal    = (move_pos <= 4'd8) && ((occupied & sel) == '0);
    assign w1       = has_line(p1_q);
    assign w2       = has_line(p2_q);
    assign full     = &occupied;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            p1w_q   <= 1'b0;
            p2w_q   <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            p1w_q   <= p1w_d;
            p2w_q   <= p2w_d;
            draw_q  <= draw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        p1w_d   = p1w_q;
        p2w_d   = p2w_q;
        draw_d  = draw_q;

        unique case (state_q)
            IDLE: begin
                if (move_valid) begin
                    if (legal) begin
                        if (player) p2_d = p2_q | sel;
                        else        p1_d = p1_q | sel;
                        ack_d   = 1'b1;
                        state_d = CHECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                // Requests arriving here are dropped; a win outranks a full board.
                p1w_d  = w1;
                p2w_d  = w2;
                draw_d = full & ~w1 & ~w2;
                state_d = (w1 | w2 | full) ? DONE : IDLE;
            end
            DONE: begin
                if (move_valid) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign move_ack = ack_q;
    assign move_err = err_q;
    assign p1_board = p1_q;
    assign p2_board = p2_q;
    assign p1_win   = p1w_q;
    assign p2_win   = p2w_q;
    assign draw     = draw_q;
    assign busy     = (state_q == CHECK);

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: directed scenarios plus random play
// compared against a cell-ownership reference model.
module tb_board_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       player;
    logic       move_ack, move_err;
    logic [8:0] p1_board, p2_board;
    logic       p1_win, p2_win, draw, busy;

    int n_tests = 0;
    int n_fail  = 0;

    board_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .player     (player),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .p1_board   (p1_board),
        .p2_board   (p2_board),
        .p1_win     (p1_win),
        .p2_win     (p2_win),
        .draw       (draw),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who owns each cell (0 none, 1 P1, 2 P2), whether the
    // cycle after an accepted move is pending evaluation, and the game result.
    int owner [9];
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    bit m_eval, m_over, m_ack, m_err, m_p1w, m_p2w, m_draw;

    function automatic logic [8:0] m_board(input int who);
        logic [8:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) if (owner[i] == who) b[i] = 1'b1;
        return b;
    endfunction

    function automatic bit m_line(input int who);
        for (int l = 0; l < 8; l++)
            if (owner[lines[l][0]] == who && owner[lines[l][1]] == who && owner[lines[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) owner[i] = 0;
        m_eval = 0; m_over = 0; m_ack = 0; m_err = 0;
        m_p1w = 0; m_p2w = 0; m_draw = 0;
    endtask

    task automatic model_edge(input bit v, input int p, input bit pl);
        bit full;
        m_ack = 0;
        m_err = 0;
        if (m_eval) begin
            full = 1;
            for (int i = 0; i < 9; i++) if (owner[i] == 0) full = 0;
            m_p1w  = m_line(1);
            m_p2w  = m_line(2);
            m_draw = full && !m_p1w && !m_p2w;
            m_over = m_p1w || m_p2w || m_draw;
            m_eval = 0;
        end else if (v) begin
            if (m_over || p > 8) m_err = 1;
            else if (owner[p] != 0) m_err = 1;
            else begin
                owner[p] = pl ? 2 : 1;
                m_ack  = 1;
                m_eval = 1;
            end
        end
    endtask

    task automatic step(input bit v, input int p, input bit pl);
        @(negedge clk);
        move_valid = v;
        move_pos   = p[3:0];
        player     = pl;
        @(posedge clk);
        model_edge(v, p, pl);
        #1;
        move_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b0;
        move_valid = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; move_valid = 1'b0; move_pos = '0; player = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({move_ack, move_err, p1_board, p2_board, p1_win, p2_win, draw, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {move_ack, move_err, p1_board, p2_board, p1_win, p2_win, draw, busy});
        end
        reset = 1'b1;
        step(1, 4, 0);
        n_tests++;
        if (move_ack !== 1'b1 || p1_board !== 9'h010 || p1_board !== m_board(1)) begin
            n_fail++;
            $display("FAIL reset_first_move: ack=%b p1_board=%h expected ack=1 p1_board=010", move_ack, p1_board);
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
    endtask

    task automatic test_row_win();
        int seq [5] = '{0, 3, 1, 4, 2};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, seq[i], i[0]);
            n_tests++;
            if (move_ack !== 1'b1 || p1_win !== 1'b0) begin
                n_fail++;
                $display("FAIL row_move%0d: ack=%b p1_win=%b expected ack=1 p1_win=0", i, move_ack, p1_win);
            end
            step(0, 0, 0);
        end
        n_tests++;
        if (p1_win !== 1'b1 || p2_win !== 1'b0 || draw !== 1'b0) begin
            n_fail++;
            $display("FAIL row_flags: p1_win=%b p2_win=%b draw=%b expected 1 0 0", p1_win, p2_win, draw);
        end
        step(1, 8, 1);
        n_tests++;
        if (move_err !== 1'b1 || move_ack !== 1'b0 || p2_board !== 9'h018 || p1_win !== 1'b1) begin
            n_fail++;
            $display("FAIL row_after_done: err=%b ack=%b p2_board=%h p1_win=%b expected 1 0 018 1",
                     move_err, move_ack, p2_board, p1_win);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        step(1, 4, 0);
        step(0, 0, 0);
        step(1, 4, 1);
        n_tests++;
        if (move_err !== 1'b1 || move_ack !== 1'b0 || p2_board !== 9'h000 || p1_board !== 9'h010) begin
            n_fail++;
            $display("FAIL illegal_occupied: err=%b ack=%b p1=%h p2=%h expected 1 0 010 000",
                     move_err, move_ack, p1_board, p2_board);
        end
        step(1, 12, 1);
        n_tests++;
        if (move_err !== 1'b1 || move_ack !== 1'b0 || p2_board !== 9'h000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_range: err=%b ack=%b p2=%h busy=%b expected 1 0 000 0",
                     move_err, move_ack, p2_board, busy);
        end
        step(1, 0, 1);
        n_tests++;
        if (move_ack !== 1'b1 || move_err !== 1'b0 || p2_board !== 9'h001) begin
            n_fail++;
            $display("FAIL illegal_recover: ack=%b err=%b p2=%h expected 1 0 001", move_ack, move_err, p2_board);
        end
    endtask

    task automatic test_draw();
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, seq[i], i[0]);
            step(0, 0, 0);
        end
        n_tests++;
        if (p1_board !== 9'h18D || p2_board !== 9'h072 || draw !== 1'b1 ||
            p1_win !== 1'b0 || p2_win !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL draw_final: p1=%h p2=%h draw=%b p1w=%b p2w=%b busy=%b expected 18d 072 1 0 0 0",
                     p1_board, p2_board, draw, p1_win, p2_win, busy);
        end
        step(1, 4, 0);
        n_tests++;
        if (move_err !== 1'b1 || move_ack !== 1'b0 || draw !== 1'b1) begin
            n_fail++;
            $display("FAIL draw_done_err: err=%b ack=%b draw=%b expected 1 0 1", move_err, move_ack, draw);
        end
        step(0, 0, 0);
        n_tests++;
        if (move_err !== 1'b0 || draw !== 1'b1 || p1_board !== 9'h18D) begin
            n_fail++;
            $display("FAIL draw_hold: err=%b draw=%b p1=%h expected 0 1 18d", move_err, draw, p1_board);
        end
    endtask

    task automatic test_busy_reset();
        apply_reset();
        step(1, 0, 0);
        n_tests++;
        if (busy !== 1'b1 || move_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_high: busy=%b ack=%b expected 1 1", busy, move_ack);
        end
        step(1, 1, 1);
        n_tests++;
        if (move_ack !== 1'b0 || move_err !== 1'b0 || p2_board !== 9'h000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore: ack=%b err=%b p2=%h busy=%b expected 0 0 000 0",
                     move_ack, move_err, p2_board, busy);
        end
        step(1, 5, 0);
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if ({move_ack, move_err, p1_board, p2_board, p1_win, p2_win, draw, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_check: got %h expected 0",
                     {move_ack, move_err, p1_board, p2_board, p1_win, p2_win, draw, busy});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1, 2, 1);
        n_tests++;
        if (move_ack !== 1'b1 || p2_board !== 9'h004 || p1_board !== 9'h000 || p1_win !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_move: ack=%b p1=%h p2=%h p1w=%b expected 1 000 004 0",
                     move_ack, p1_board, p2_board, p1_win);
        end
    endtask

    task automatic test_random();
        logic [23:0] got, exp;
        bit v, pl;
        int p;
        for (int g = 0; g < 8; g++) begin
            apply_reset();
            for (int c = 0; c < 60; c++) begin
                v  = ($urandom_range(0, 9) < 7);
                p  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
                pl = $urandom_range(0, 1);
                step(v, p, pl);
                got = {move_ack, move_err, p1_board, p2_board, p1_win, p2_win, draw, busy};
                exp = {m_ack, m_err, m_board(1), m_board(2), m_p1w, m_p2w, m_draw, m_eval};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random g%0d c%0d: got %h expected %h (ack,err,p1,p2,p1w,p2w,draw,busy)",
                             g, c, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_row_win();
        test_illegal();
        test_draw();
        test_busy_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
